// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and round-robin index helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic int next_rr_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker returning the first set request at or after start
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [N-1:0] rot;
  // Rotate so start sits at bit 0, then take the lowest set bit and map it back
  always_comb begin
    rot = N'({req, req} >> start);
    found = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (|(rot & (N'(1) << k))) idx = IW'(int'(start) + k >= N ? int'(start) + k - N : int'(start) + k);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among valid/ready producers
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [CNT_WIDTH-1:0]          wr_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_t state, state_n;
  logic [IW-1:0] owner, owner_n, last_owner, last_n, start, pick_idx;
  logic [BW-1:0] beat_cnt, beat_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic gnt, xfer, rel, found;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .start (start),
    .found (found),
    .idx   (pick_idx)
  );

  // Same-cycle transfer path; reset masks everything so a mid-burst reset writes nothing
  always_comb begin
    gnt = (state == GRANT) & ~rst;
    xfer = gnt & req_valid[owner] & ~fifo_full;
    rel = gnt & ((xfer & (beat_cnt == BW'(BURST_MAX - 1))) | ~req_valid[owner]);
    start = IW'(next_rr_idx(int'(state == GRANT ? owner : last_owner), NUM_REQ));
    fifo_w_en = xfer;
    req_ready = xfer ? NUM_REQ'(1) << owner : '0;
    fifo_data = gnt ? DATA_WIDTH'(req_data >> (int'(owner) * DATA_WIDTH)) : '0;
    grant_valid = gnt;
    grant_id = rst ? '0 : owner;
  end

  // Arbitrate from IDLE or on release, otherwise count beats of the held grant
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n = rel ? owner : last_owner;
    beat_n = xfer ? beat_cnt + BW'(1) : beat_cnt;
    cnt_n = wr_count + CNT_WIDTH'(xfer);
    if (state == IDLE || rel) begin
      state_n = found ? GRANT : IDLE;
      owner_n = found ? pick_idx : owner;
      beat_n = '0;
    end
  end

  // State register; producer 0 wins first after reset because the scan starts after NUM_REQ-1
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
      wr_count <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last_owner <= last_n;
      beat_cnt <= beat_n;
      wr_count <= cnt_n;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks against a behavioural arbitration model
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, B = 4, CW = 16;
  logic clk = 0, rst = 1, fifo_full = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [DW-1:0] pdata [N];
  logic [N*DW-1:0] req_data;
  logic fifo_w_en, grant_valid;
  logic [DW-1:0] fifo_data;
  logic [1:0] grant_id;
  logic [CW-1:0] wr_count;
  int checks = 0, errors = 0;
  bit m_busy = 0, last_x;
  int m_own = 0, m_last = N - 1, m_beats = 0, m_wr = 0, last_id, cyc, n;
  logic [DW-1:0] wlog [$];
  int glog [$];

  assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};
  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(B), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_w_en(fifo_w_en), .fifo_data(fifo_data),
    .grant_valid(grant_valid), .grant_id(grant_id), .wr_count(wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit vbit(input logic [N-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int from);
    for (int i = 0; i < N; i++) if (vbit(v, (from + i) % N)) return (from + i) % N;
    return -1;
  endfunction

  task automatic step();
    bit busy, x;
    int j;
    @(negedge clk);
    busy = m_busy && !rst;
    x = busy && vbit(req_valid, m_own) && !fifo_full;
    chk("w_en", 32'(fifo_w_en), 32'(x));
    chk("req_ready", 32'(req_ready), x ? 32'(1) << m_own : 32'd0);
    chk("fifo_data", 32'(fifo_data), busy ? 32'(pdata[m_own]) : 32'd0);
    chk("grant_valid", 32'(grant_valid), 32'(busy));
    chk("grant_id", 32'(grant_id), rst ? 32'd0 : 32'(m_own));
    chk("wr_count", 32'(wr_count), 32'(m_wr % 65536));
    if (fifo_w_en) begin
      wlog.push_back(fifo_data);
      glog.push_back(int'(grant_id));
    end
    last_x = x;
    last_id = m_own;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_own = 0; m_last = N - 1; m_beats = 0; m_wr = 0;
    end else if (!m_busy) begin
      j = pick(req_valid, (m_last + 1) % N);
      if (j >= 0) begin m_busy = 1; m_own = j; m_beats = 0; end
    end else begin
      if (x) begin m_wr++; m_beats++; end
      if ((x && m_beats == B) || !vbit(req_valid, m_own)) begin
        m_last = m_own;
        m_beats = 0;
        j = pick(req_valid, (m_own + 1) % N);
        if (j >= 0) m_own = j; else m_busy = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) pdata[i] = 8'(i);
    req_valid = 4'hF;
    @(posedge clk);
    #1;
    // reset with every producer requesting, then the first grant goes to 0
    do_reset();
    chk("t1_wr_count", 32'(wr_count), 0);
    step();
    #3;
    chk("t1_first_gid", 32'(grant_id), 0);
    chk("t1_first_gv", 32'(grant_valid), 1);
    // single producer, six beats
    req_valid = 0;
    do_reset();
    req_valid = 4'b0100;
    pdata[2] = 8'h10;
    wlog.delete();
    cyc = 0; n = 0;
    while (n < 6 && cyc < 20) begin
      step();
      cyc++;
      if (last_x) begin
        n++;
        pdata[2] = pdata[2] + 8'd1;
        if (n == 6) req_valid = 0;
      end
    end
    chk("t2_cycles", 32'(cyc), 7);
    chk("t2_wr_count", 32'(wr_count), 6);
    chk("t2_nwrites", 32'(wlog.size()), 6);
    for (int i = 0; i < wlog.size(); i++) chk("t2_data", 32'(wlog[i]), 32'(8'h10 + i));
    // fairness with all four requesting
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) pdata[i] = 8'(8'h20 + 16 * i);
    glog.delete();
    repeat (17) begin
      step();
      if (last_x) pdata[last_id] = pdata[last_id] + 8'd1;
    end
    chk("t3_wr_count", 32'(wr_count), 16);
    chk("t3_nwrites", 32'(glog.size()), 16);
    for (int i = 0; i < glog.size(); i++) chk("t3_order", 32'(glog[i]), 32'(i / 4));
    chk("t3_regrant", 32'(grant_id), 0);
    // full stall mid-burst of owner 1
    req_valid = 0;
    do_reset();
    req_valid = 4'b0010;
    pdata[1] = 8'h40;
    repeat (3) begin
      step();
      if (last_x) pdata[1] = pdata[1] + 8'd1;
    end
    fifo_full = 1;
    req_valid = 4'b0011;
    repeat (5) begin
      step();
      chk("t4_hold_gid", 32'(grant_id), 1);
    end
    fifo_full = 0;
    glog.delete();
    repeat (4) begin
      step();
      if (last_x) pdata[last_id] = pdata[last_id] + 8'd1;
    end
    chk("t4_nwrites", 32'(glog.size()), 4);
    for (int i = 0; i < glog.size(); i++) chk("t4_order", 32'(glog[i]), i < 2 ? 32'd1 : 32'd0);
    // early release by owner 3 while 0 waits
    req_valid = 0;
    do_reset();
    req_valid = 4'b1000;
    step();
    step();
    req_valid = 4'b0001;
    pdata[0] = 8'h55;
    step();
    #3;
    chk("t5_gid", 32'(grant_id), 0);
    chk("t5_gv", 32'(grant_valid), 1);
    chk("t5_wen", 32'(fifo_w_en), 1);
    chk("t5_data", 32'(fifo_data), 32'h55);
    // reset in the middle of owner 2's burst
    req_valid = 0;
    do_reset();
    req_valid = 4'b0100;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    chk("t6_gv", 32'(grant_valid), 0);
    chk("t6_wr_count", 32'(wr_count), 0);
    req_valid = 4'b0101;
    step();
    chk("t6_gid", 32'(grant_id), 0);
    chk("t6_gv2", 32'(grant_valid), 1);
    // randomized traffic with stalls, dropped valids and occasional resets
    req_valid = 0;
    do_reset();
    repeat (800) begin
      rst = ($urandom_range(0, 199) == 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      step();
      if (last_x) begin
        pdata[last_id] = 8'($urandom);
        if ($urandom_range(0, 2) == 0) req_valid = req_valid & ~(4'(1) << last_id);
      end
      for (int i = 0; i < N; i++)
        if (!vbit(req_valid, i) && $urandom_range(0, 2) == 0) begin
          pdata[i] = 8'($urandom);
          req_valid = req_valid | (4'(1) << i);
        end else if (vbit(req_valid, i) && $urandom_range(0, 29) == 0)
          req_valid = req_valid & ~(4'(1) << i);
    end
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
